axi4_lite_cmd_master: RTL

Single-outstanding AXI4-Lite master. It converts a simple valid/ready command stream into AXI4-Lite read or write transactions, and returns each result on a valid/ready response stream. It sits directly upstream of the register-file slave and drives that slave's five channels; the command side is fed by a test sequencer or control CPU bridge. Exactly one transaction is in flight at any time.

---
 rtl/axi4_lite_cmd_master_if.sv | 51 +++++
 rtl/axi4_lite_cmd_master.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/axi4_lite_cmd_master_if.sv
// Bundle of the command/response stream and the five AXI4-Lite channels
// between the command master and the register-file slave.
interface axi4_lite_cmd_master_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;
   logic [3:0]            cmd_wstrb;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic                  rsp_write;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic [1:0]            rsp_resp;

   logic [ADDR_WIDTH-1:0] awaddr;
   logic                  awvalid;
   logic                  awready;
   logic [DATA_WIDTH-1:0] wdata;
   logic [3:0]            wstrb;
   logic                  wvalid;
   logic                  wready;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic                  arvalid;
   logic                  arready;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rready;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
      output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
      input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready
   );
endinterface

// File: rtl/axi4_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI transaction,
// one response out.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a command; cmd_ready high
// WR_REQ  | AW and W offered; each valid drops on its own handshake
// WR_RESP | bready high, waiting for the write response
// RD_REQ  | AR offered until arready
// RD_RESP | rready high, waiting for read data
// RSP     | rsp_valid high with captured result until rsp_ready
module axi4_lite_cmd_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input logic                    aclk_i,
   input logic                    aresetn_i,
   axi4_lite_cmd_master_if.master bus_if
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_RESP = 3'd4,
      RSP     = 3'd5
   } state_t;

   state_t                state_q, state_d;
   logic                  awvalid_q, awvalid_d;
   logic                  wvalid_q, wvalid_d;
   logic                  arvalid_q, arvalid_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [3:0]            wstrb_q, wstrb_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [1:0]            rsp_resp_q, rsp_resp_d;
   logic                  rsp_write_q, rsp_write_d;

   logic                  aw_done;
   logic                  w_done;

   // A channel counts as done if it already handshook or handshakes now.
   assign aw_done = !awvalid_q || bus_if.awready;
   assign w_done  = !wvalid_q  || bus_if.wready;

   // Next-state and payload decode.
   always_comb begin
      state_d     = state_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      arvalid_d   = arvalid_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_resp_d  = rsp_resp_q;
      rsp_write_d = rsp_write_q;

      case (state_q)
         IDLE: begin
            if (bus_if.cmd_valid) begin
               addr_d  = bus_if.cmd_addr;
               wdata_d = bus_if.cmd_wdata;
               wstrb_d = bus_if.cmd_wstrb;
               if (bus_if.cmd_write) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = WR_REQ;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = RD_REQ;
               end
            end
         end
         WR_REQ: begin
            if (awvalid_q && bus_if.awready) awvalid_d = 1'b0;
            if (wvalid_q && bus_if.wready)   wvalid_d  = 1'b0;
            if (aw_done && w_done)           state_d   = WR_RESP;
         end
         WR_RESP: begin
            if (bus_if.bvalid) begin
               rsp_resp_d  = bus_if.bresp;
               rsp_rdata_d = '0;
               rsp_write_d = 1'b1;
               state_d     = RSP;
            end
         end
         RD_REQ: begin
            if (bus_if.arready) begin
               arvalid_d = 1'b0;
               state_d   = RD_RESP;
            end
         end
         RD_RESP: begin
            if (bus_if.rvalid) begin
               rsp_rdata_d = bus_if.rdata;
               rsp_resp_d  = bus_if.rresp;
               rsp_write_d = 1'b0;
               state_d     = RSP;
            end
         end
         RSP: begin
            if (bus_if.rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and payload registers with synchronous active-low reset.
   always_ff @(posedge aclk_i) begin
      if (!aresetn_i) begin
         state_q     <= IDLE;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= '0;
         rsp_write_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         arvalid_q   <= arvalid_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_resp_q  <= rsp_resp_d;
         rsp_write_q <= rsp_write_d;
      end
   end

   // Ready/valid outputs come straight from the registered state so no
   // input can reach them combinationally.
   assign bus_if.cmd_ready = (state_q == IDLE);
   assign bus_if.bready    = (state_q == WR_RESP);
   assign bus_if.rready    = (state_q == RD_RESP);
   assign bus_if.rsp_valid = (state_q == RSP);

   assign bus_if.awvalid   = awvalid_q;
   assign bus_if.wvalid    = wvalid_q;
   assign bus_if.arvalid   = arvalid_q;
   assign bus_if.awaddr    = addr_q;
   assign bus_if.araddr    = addr_q;
   assign bus_if.wdata     = wdata_q;
   assign bus_if.wstrb     = wstrb_q;
   assign bus_if.rsp_rdata = rsp_rdata_q;
   assign bus_if.rsp_resp  = rsp_resp_q;
   assign bus_if.rsp_write = rsp_write_q;

endmodule
